// File: rtl/uart_tx_buf.sv
// UART transmitter (8N1, LSB first) with a one-entry holding register so frames can go out back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_buf #(
  parameter logic [15:0] BPS_NUM = 16'd434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  // Handshake: tx_data transfers on a rising edge where tx_en && tx_ready; tx_en while tx_ready=0 is dropped.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t      state;
  logic [7:0]  hold_data;
  logic        hold_full;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [15:0] cnt;
  logic        wrap;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit;
`endif

  assign wrap   = (cnt == BPS_NUM);
  assign accept = tx_en && tx_ready;

  // Bit-period divider; parked at zero while idle so the start bit is a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (state == IDLE || wrap) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_data <= 8'd0;
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
      shift     <= 8'd0;
      bit_cnt   <= 3'd0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;

      // Accept and load are mutually exclusive: a full holding register keeps tx_ready low.
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (hold_full) begin
            state     <= START;
            shift     <= hold_data;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
            bit_cnt   <= 3'd0;
            uart_tx   <= 1'b0;
            tx_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^hold_data;
`endif
          end
        end

        START: begin
          if (wrap) begin
            state   <= DATA;
            uart_tx <= shift[0];
          end
        end

        DATA: begin
          if (wrap) begin
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              uart_tx <= parity_bit;
`else
              state   <= STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              uart_tx <= shift[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (wrap) begin
            state   <= STOP;
            uart_tx <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (wrap) begin
            tx_done <= 1'b1;
            if (hold_full) begin
              // Next start bit follows the stop bit directly, no idle gap.
              state     <= START;
              shift     <= hold_data;
              hold_full <= 1'b0;
              tx_ready  <= 1'b1;
              bit_cnt   <= 3'd0;
              uart_tx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^hold_data;
`endif
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  ready_mirrors_hold: assert property (@(posedge clk) disable iff (!rst_n) tx_ready == !hold_full);
  busy_mirrors_state: assert property (@(posedge clk) disable iff (!rst_n) tx_busy == (state != IDLE));
  line_high_in_idle:  assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> uart_tx);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf at BPS_NUM=4: cycle-exact waveform vectors plus a serial decoder feeding a scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_buf;

  localparam logic [15:0] BPS = 16'd4;
  localparam int P = 5;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_en = 1'b0;
  logic       tx_ready, tx_busy, tx_done, uart_tx;

  int n_checks = 0;
  int n_fail = 0;
  int n_sent = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[9];

  uart_tx_buf #(.BPS_NUM(BPS)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_en(tx_en),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(d);
    n_sent++;
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_done) done_cnt <= done_cnt + 1;
  end

  // Serial decoder: samples the centre of each bit and checks against the scoreboard.
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'd0;
`ifdef UART_TX_PARITY_EN
  logic       dec_par = 1'b0;
`endif
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_active <= 1'b0;
      dec_cnt    <= 0;
    end else if (!dec_active) begin
      if (uart_tx == 1'b0) begin
        dec_active <= 1'b1;
        dec_cnt    <= 1;
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if (dec_cnt % P == 2) begin
        if (dec_cnt / P == 0) begin
          check("rx_start", uart_tx, 0);
        end else if (dec_cnt / P <= 8) begin
          dec_byte <= {uart_tx, dec_byte[7:1]};
`ifdef UART_TX_PARITY_EN
        end else if (dec_cnt / P == 9) begin
          dec_par <= uart_tx;
`endif
        end else begin
          check("rx_stop", uart_tx, 1);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", dec_par, ^dec_byte);
`endif
          check("rx_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", dec_byte, exp_q.pop_front());
          dec_active <= 1'b0;
        end
      end
    end
  end

  task automatic capture(input int n, output logic [127:0] lw, output logic [127:0] dw,
                         output logic [127:0] bw, output logic [127:0] rw);
    lw = '1; dw = '0; bw = '0; rw = '1;
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      lw[t] = uart_tx; dw[t] = tx_done; bw[t] = tx_busy; rw[t] = tx_ready;
    end
  endtask

  // Expected waveforms, offset 0 = first negedge after the accept edge of the first byte.
  function automatic void build_exp(input logic [7:0] b0, input logic p0, input logic [7:0] b1,
                                    input logic p1, input int nb, output logic [127:0] lw,
                                    output logic [127:0] dw, output logic [127:0] bw,
                                    output logic [127:0] rw);
    logic [10:0] fr;
    logic [7:0]  b;
    logic        p;
    lw = '1; dw = '0; bw = '0; rw = '1;
    rw[0] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      b = (i == 0) ? b0 : b1;
      p = (i == 0) ? p0 : p1;
      fr = '1;
      fr[0] = 1'b0;
      fr[8:1] = b;
`ifdef UART_TX_PARITY_EN
      fr[9] = p;
`else
      fr[9] = 1'b1 | p;
`endif
      for (int s = 0; s < F; s++)
        for (int k = 0; k < P; k++) begin
          lw[1 + i*F*P + s*P + k] = fr[s];
          bw[1 + i*F*P + s*P + k] = 1'b1;
        end
      dw[1 + (i+1)*F*P] = 1'b1;
    end
    if (nb == 2)
      for (int t = 2; t <= F*P; t++) rw[t] = 1'b0;
  endfunction

  task automatic run_single(input int idx, input logic [7:0] d, input logic p);
    logic [127:0] lw, dw, bw, rw, el, ed, eb, er;
    @(negedge clk);
    check($sformatf("vec%0d_ready_before", idx), tx_ready, 1);
    tx_data = d; tx_en = 1'b1; push_exp(d);
    @(posedge clk);
    fork
      capture(F*P + 1, lw, dw, bw, rw);
      begin @(negedge clk); tx_en = 1'b0; end
    join
    build_exp(d, p, 8'd0, 1'b0, 1, el, ed, eb, er);
    check($sformatf("vec%0d_line", idx), lw, el);
    check($sformatf("vec%0d_done", idx), dw, ed);
    check($sformatf("vec%0d_busy", idx), bw, eb);
    check($sformatf("vec%0d_ready", idx), rw, er);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (!tx_ready && k < 4*F*P) begin @(negedge clk); k++; end
    check("send_ready", tx_ready, 1);
    if (tx_ready) begin
      tx_data = d; tx_en = 1'b1; push_exp(d);
      @(negedge clk);
      tx_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] lw, dw, bw, rw, el, ed, eb, er;
    logic ok;
    int k;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'hA5, 1'b0};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'h07, 1'b1};
    vecs[6] = '{8'h03, 1'b0};
    vecs[7] = '{8'h80, 1'b1};
    vecs[8] = '{8'h01, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {uart_tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_outputs", {uart_tx, tx_ready, tx_busy, tx_done}, 4'b1100);

    for (int i = 0; i < 9; i++) run_single(i, vecs[i].data, vecs[i].par);

    // Back-to-back: second byte offered as soon as tx_ready rises.
    @(negedge clk);
    tx_data = 8'hA5; tx_en = 1'b1; push_exp(8'hA5);
    @(posedge clk);
    fork
      capture(2*F*P + 1, lw, dw, bw, rw);
      begin
        ok = 1'b0;
        @(negedge clk);
        tx_en = 1'b0;
        for (int j = 0; j < 10 && !ok; j++) begin
          @(negedge clk);
          if (tx_ready) begin
            tx_data = 8'h3C; tx_en = 1'b1; push_exp(8'h3C);
            @(negedge clk);
            tx_en = 1'b0;
            ok = 1'b1;
          end
        end
        check("b2b_offer", ok, 1);
      end
    join
    build_exp(8'hA5, 1'b0, 8'h3C, 1'b0, 2, el, ed, eb, er);
    check("b2b_line", lw, el);
    check("b2b_done", dw, ed);
    check("b2b_busy", bw, eb);
    check("b2b_ready", rw, er);

    // tx_en held high with 0xFF while the holding register is busy during a 0x00 frame.
    @(negedge clk);
    tx_data = 8'h00; tx_en = 1'b1; push_exp(8'h00);
    @(posedge clk);
    fork
      capture(2*F*P + 1, lw, dw, bw, rw);
      begin
        ok = 1'b0;
        @(negedge clk);
        tx_data = 8'hFF; push_exp(8'hFF);
        for (int j = 0; j < 10 && !ok; j++) begin
          if (tx_ready) begin
            @(negedge clk);
            tx_en = 1'b0;
            ok = 1'b1;
          end else begin
            @(negedge clk);
          end
        end
        tx_en = 1'b0;
        check("held_accept", ok, 1);
      end
    join
    build_exp(8'h00, 1'b0, 8'hFF, 1'b0, 2, el, ed, eb, er);
    check("held_line", lw, el);
    check("held_done", dw, ed);
    check("held_ready", rw, er);
    capture(F*P, lw, dw, bw, rw);
    check("held_no_third_line", lw, {128{1'b1}});
    check("held_no_third_done", dw, 128'd0);

    // Reset in the middle of data bit 3 with a second byte waiting in the holding register.
    @(negedge clk);
    tx_data = 8'h55; tx_en = 1'b1; push_exp(8'h55);
    @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    @(negedge clk);
    tx_data = 8'h3C; tx_en = 1'b1; push_exp(8'h3C);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (21) @(negedge clk);
    check("rst_mid_bit3_line", uart_tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {uart_tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    n_sent = n_sent - exp_q.size();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    capture(2*F*P, lw, dw, bw, rw);
    check("rst_after_line", lw, {128{1'b1}});
    check("rst_after_done", dw, 128'd0);
    check("rst_after_busy", bw, 128'd0);
    check("rst_after_ready", rw, {128{1'b1}});

    // Random bytes with random gaps, checked by the decoder scoreboard.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 40*F*P) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    check("done_count", done_cnt, n_sent);
    check("final_idle", {uart_tx, tx_ready, tx_busy}, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
